// File: rtl/eth_rx_mii_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles (low first) into bytes, ends each frame with a status strobe.
// Optional FCS residue checking is built only when ETH_RX_CRC_CHECK_EN is defined.
module eth_rx_mii_deframer #(
    parameter int MIN_PRE_NIB = 2,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1518
) (
    input  logic        MRxclk,
    input  logic        MRxrst,
    input  logic        rx_en_i,
    input  logic [3:0]  MRxD,
    input  logic        MRxdv,
    input  logic        MRxerr,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_sof_o,
    output logic        rx_done_o,
    output logic [15:0] rx_len_o,
    output logic        rx_err_o,
    output logic        rx_dribble_o,
    output logic        rx_short_o,
    output logic        rx_long_o,
    output logic        rx_crc_err_o,
    output logic        rx_busy_o
);
    localparam logic [3:0]  PRE_MIN = 4'(MIN_PRE_NIB);
    localparam logic [15:0] LEN_MIN = 16'(MIN_LEN);
    localparam logic [15:0] LEN_MAX = 16'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_FLUSH, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic        phase_q, phase_d;
    logic [3:0]  low_q, low_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic        dribble_q, dribble_d;
    logic        long_q, long_d;

    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        done_q, done_d;
    logic [15:0] len_o_q, len_o_d;
    logic        err_o_q, err_o_d;
    logic        dribble_o_q, dribble_o_d;
    logic        short_o_q, short_o_d;
    logic        long_o_q, long_o_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        phase_d     = phase_q;
        low_d       = low_q;
        len_d       = len_q;
        err_d       = err_q;
        dribble_d   = dribble_q;
        long_d      = long_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        done_d      = 1'b0;
        len_o_d     = len_o_q;
        err_o_d     = err_o_q;
        dribble_o_d = dribble_o_q;
        short_o_d   = short_o_q;
        long_o_d    = long_o_q;

        case (state_q)
            S_IDLE: begin
                if (MRxdv) begin
                    if (rx_en_i && (MRxD == 4'h5)) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (!MRxdv) begin
                    state_d = S_IDLE;
                end else if (MRxD == 4'h5) begin
                    if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
                end else if ((MRxD == 4'hD) && (pre_cnt_q >= PRE_MIN)) begin
                    state_d   = S_DATA;
                    phase_d   = 1'b0;
                    len_d     = 16'd0;
                    err_d     = 1'b0;
                    dribble_d = 1'b0;
                    long_d    = 1'b0;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DATA: begin
                if (MRxerr) err_d = 1'b1;
                if (!MRxdv) begin
                    state_d   = S_FLUSH;
                    dribble_d = phase_q;
                end else if (!phase_q) begin
                    low_d   = MRxD;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    // The byte that would overrun MAX_LEN is swallowed, not emitted.
                    if (len_q >= LEN_MAX) begin
                        long_d  = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        data_d  = {MRxD, low_q};
                        valid_d = 1'b1;
                        sof_d   = (len_q == 16'd0);
                        len_d   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    end
                end
            end
            S_FLUSH: begin
                done_d      = 1'b1;
                len_o_d     = len_q;
                err_o_d     = err_q;
                dribble_o_d = dribble_q;
                short_o_d   = (len_q < LEN_MIN);
                long_o_d    = long_q;
                state_d     = MRxdv ? S_DROP : S_IDLE;
            end
            S_DROP: begin
                if (!MRxdv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge MRxclk) begin
        if (MRxrst) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= 4'd0;
            phase_q     <= 1'b0;
            low_q       <= 4'd0;
            len_q       <= 16'd0;
            err_q       <= 1'b0;
            dribble_q   <= 1'b0;
            long_q      <= 1'b0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            done_q      <= 1'b0;
            len_o_q     <= 16'd0;
            err_o_q     <= 1'b0;
            dribble_o_q <= 1'b0;
            short_o_q   <= 1'b0;
            long_o_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            phase_q     <= phase_d;
            low_q       <= low_d;
            len_q       <= len_d;
            err_q       <= err_d;
            dribble_q   <= dribble_d;
            long_q      <= long_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            done_q      <= done_d;
            len_o_q     <= len_o_d;
            err_o_q     <= err_o_d;
            dribble_o_q <= dribble_o_d;
            short_o_q   <= short_o_d;
            long_o_q    <= long_o_d;
            busy_q      <= busy_d;
        end
    end

`ifdef ETH_RX_CRC_CHECK_EN
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    logic [31:0] crc_q, crc_d;
    logic        crc_init;
    logic        crc_err_q;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_init = (state_q == S_PRE) && (state_d == S_DATA);

    always_comb begin
        crc_d = crc_q;
        if (crc_init)     crc_d = 32'hFFFFFFFF;
        else if (valid_d) crc_d = crc32_byte(crc_q, data_d);
    end

    // Residue compare runs on the raw register, FCS bytes already folded in.
    always_ff @(posedge MRxclk) begin
        if (MRxrst) begin
            crc_q     <= 32'd0;
            crc_err_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            if (state_q == S_FLUSH) crc_err_q <= (crc_q != CRC_RESIDUE) | long_q;
        end
    end

    assign rx_crc_err_o = crc_err_q;
`else
    assign rx_crc_err_o = 1'b0;
`endif

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign rx_sof_o     = sof_q;
    assign rx_done_o    = done_q;
    assign rx_len_o     = len_o_q;
    assign rx_err_o     = err_o_q;
    assign rx_dribble_o = dribble_o_q;
    assign rx_short_o   = short_o_q;
    assign rx_long_o    = long_o_q;
    assign rx_busy_o    = busy_q;

endmodule

// File: tb/tb_eth_rx_mii_deframer.sv
// Directed bench for eth_rx_mii_deframer: good/corrupt/err/dribble/long frames, preamble limits, enable, reset.
`timescale 1ns/1ps
module tb_eth_rx_mii_deframer;
`ifdef ETH_RX_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic        MRxclk = 1'b0;
    logic        MRxrst, rx_en_i, MRxdv, MRxerr;
    logic [3:0]  MRxD;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_sof_o, rx_done_o;
    logic [15:0] rx_len_o;
    logic        rx_err_o, rx_dribble_o, rx_short_o, rx_long_o, rx_crc_err_o, rx_busy_o;

    always #5 MRxclk = ~MRxclk;

    eth_rx_mii_deframer dut (
        .MRxclk(MRxclk), .MRxrst(MRxrst), .rx_en_i(rx_en_i), .MRxD(MRxD),
        .MRxdv(MRxdv), .MRxerr(MRxerr), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_sof_o(rx_sof_o), .rx_done_o(rx_done_o), .rx_len_o(rx_len_o), .rx_err_o(rx_err_o),
        .rx_dribble_o(rx_dribble_o), .rx_short_o(rx_short_o), .rx_long_o(rx_long_o),
        .rx_crc_err_o(rx_crc_err_o), .rx_busy_o(rx_busy_o)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: cumulative counters and byte log, sampled on the falling edge.
    int          vld_total = 0, done_total = 0, sof_total = 0, both_total = 0;
    logic [7:0]  sof_byte = 8'h0;
    logic [7:0]  rx_log [0:4095];
    logic [15:0] d_len = 16'h0;
    logic        d_err = 1'b0, d_drib = 1'b0, d_short = 1'b0, d_long = 1'b0, d_crc = 1'b0;

    always @(negedge MRxclk) begin
        if (rx_valid_o) begin
            rx_log[vld_total % 4096] <= rx_data_o;
            vld_total <= vld_total + 1;
            if (rx_sof_o) begin
                sof_total <= sof_total + 1;
                sof_byte  <= rx_data_o;
            end
        end
        if (rx_done_o) begin
            done_total <= done_total + 1;
            d_len   <= rx_len_o;
            d_err   <= rx_err_o;
            d_drib  <= rx_dribble_o;
            d_short <= rx_short_o;
            d_long  <= rx_long_o;
            d_crc   <= rx_crc_err_o;
        end
        if (rx_valid_o && rx_done_o) both_total <= both_total + 1;
    end

    logic [7:0] frm [0:1599];

    function automatic logic [31:0] fcs_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Payload 0,1,2,... followed by the 4 FCS bytes, least significant first.
    task automatic build_frame(input int npay);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < npay; i++) begin
            frm[i] = 8'(i);
            c = fcs_step(c, frm[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm[npay + k] = c[8*k +: 8];
    endtask

    task automatic send_nib(input logic [3:0] d, input logic dv, input logic er);
        @(negedge MRxclk);
        MRxD   = d;
        MRxdv  = dv;
        MRxerr = er;
    endtask

    task automatic send_frame(input int nbytes, input int npre, input bit extra, input int err_at);
        logic [7:0] b;
        for (int i = 0; i < npre; i++) send_nib(4'h5, 1'b1, 1'b0);
        send_nib(4'hD, 1'b1, 1'b0);
        for (int j = 0; j < nbytes; j++) begin
            b = frm[j];
            send_nib(b[3:0], 1'b1, (j == err_at));
            send_nib(b[7:4], 1'b1, 1'b0);
        end
        if (extra) send_nib(4'hA, 1'b1, 1'b0);
        send_nib(4'h0, 1'b0, 1'b0);
        repeat (5) @(negedge MRxclk);
        #2;
    endtask

    task automatic check_rx(input string t, input int v0, input int d0, input int s0, input int nv,
                            input int len, input logic er, input logic dr, input logic sh,
                            input logic lg, input logic cr);
        int bad;
        check_val({t, ".nvld"}, vld_total - v0, nv);
        check_val({t, ".ndone"}, done_total - d0, 1);
        check_val({t, ".nsof"}, sof_total - s0, 1);
        check_val({t, ".sofbyte"}, sof_byte, frm[0]);
        bad = 0;
        for (int j = 0; j < nv; j++) if (rx_log[(v0 + j) % 4096] !== frm[j]) bad++;
        check_val({t, ".bytes"}, bad, 0);
        check_val({t, ".len"}, d_len, len);
        check_val({t, ".err"}, d_err, er);
        check_val({t, ".dribble"}, d_drib, dr);
        check_val({t, ".short"}, d_short, sh);
        check_val({t, ".long"}, d_long, lg);
        check_val({t, ".crc"}, d_crc, cr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, d0, s0;
        MRxrst = 1'b1; rx_en_i = 1'b1; MRxD = 4'h0; MRxdv = 1'b0; MRxerr = 1'b0;
        repeat (4) @(negedge MRxclk);
        #2;
        check_val("rst.valid", rx_valid_o, 0);
        check_val("rst.done", rx_done_o, 0);
        check_val("rst.len", rx_len_o, 0);
        check_val("rst.data", rx_data_o, 0);
        check_val("rst.busy", rx_busy_o, 0);
        MRxrst = 1'b0;
        repeat (2) @(negedge MRxclk);

        build_frame(60);
        v0 = vld_total; d0 = done_total; s0 = sof_total;
        send_frame(64, 15, 0, -1);
        check_rx("good", v0, d0, s0, 64, 64, 0, 0, 0, 0, 0);
        repeat (3) @(negedge MRxclk);
        #2;
        check_val("good.hold_len", rx_len_o, 64);
        check_val("good.idle_busy", rx_busy_o, 0);

        frm[10] = frm[10] ^ 8'hFF;
        v0 = vld_total; d0 = done_total; s0 = sof_total;
        send_frame(64, 15, 0, -1);
        check_rx("corrupt", v0, d0, s0, 64, 64, 0, 0, 0, 0, CRC_ON);

        build_frame(60);
        v0 = vld_total; d0 = done_total; s0 = sof_total;
        send_frame(64, 15, 0, 30);
        check_rx("mrxerr", v0, d0, s0, 64, 64, 1, 0, 0, 0, 0);

        build_frame(16);
        v0 = vld_total; d0 = done_total; s0 = sof_total;
        send_frame(20, 15, 1, -1);
        check_rx("dribble", v0, d0, s0, 20, 20, 0, 1, 1, 0, 0);

        v0 = vld_total; d0 = done_total; s0 = sof_total;
        send_frame(20, 2, 0, -1);
        check_rx("minpre", v0, d0, s0, 20, 20, 0, 0, 1, 0, 0);

        v0 = vld_total; d0 = done_total;
        send_frame(20, 1, 0, -1);
        check_val("shortpre.nvld", vld_total - v0, 0);
        check_val("shortpre.ndone", done_total - d0, 0);

        rx_en_i = 1'b0;
        v0 = vld_total; d0 = done_total;
        send_frame(20, 15, 0, -1);
        check_val("disabled.nvld", vld_total - v0, 0);
        check_val("disabled.ndone", done_total - d0, 0);
        rx_en_i = 1'b1;

        build_frame(1596);
        v0 = vld_total; d0 = done_total; s0 = sof_total;
        send_frame(1600, 15, 0, -1);
        check_rx("long", v0, d0, s0, 1518, 1518, 0, 0, 0, 1, CRC_ON);

        // Bad preamble nibble, then a second frame cut by reset just after SFD.
        build_frame(60);
        v0 = vld_total; d0 = done_total;
        send_nib(4'h5, 1'b1, 1'b0);
        send_nib(4'h5, 1'b1, 1'b0);
        send_nib(4'h5, 1'b1, 1'b0);
        send_nib(4'h3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_nib(4'h5, 1'b1, 1'b0);
        send_nib(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_nib(4'(i), 1'b1, 1'b0);
        send_nib(4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge MRxclk);
        for (int i = 0; i < 15; i++) send_nib(4'h5, 1'b1, 1'b0);
        send_nib(4'hD, 1'b1, 1'b0);
        #2;
        check_val("rst2.busy_pre", rx_busy_o, 1);
        @(negedge MRxclk);
        MRxrst = 1'b1; MRxD = 4'h1; MRxdv = 1'b1;
        @(negedge MRxclk);
        MRxD = 4'h2;
        @(negedge MRxclk);
        MRxdv = 1'b0;
        @(negedge MRxclk);
        MRxrst = 1'b0;
        repeat (4) @(negedge MRxclk);
        #2;
        check_val("rst2.nvld", vld_total - v0, 0);
        check_val("rst2.ndone", done_total - d0, 0);
        check_val("rst2.len", rx_len_o, 0);
        check_val("rst2.long", rx_long_o, 0);
        check_val("rst2.crc", rx_crc_err_o, 0);
        check_val("rst2.data", rx_data_o, 0);
        check_val("rst2.busy", rx_busy_o, 0);
        check_val("overlap.valid_done", both_total, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
